// File: rtl/prog_delay_pkg.sv
// ============================================================================
//  prog_delay_pkg
//  Shared types, constants and the delay-legality helper for prog_delay_line.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package prog_delay_pkg;

  localparam int          DEFAULT_WIDTH = 24;
  localparam int unsigned DELAY_MIN     = 1;

  typedef logic [DEFAULT_WIDTH-1:0] lane_t;

  function automatic logic legal_delay(input int unsigned d, input int unsigned depth);
    return (d >= DELAY_MIN) && (d <= depth);
  endfunction

endpackage

`default_nettype wire

// File: rtl/prog_delay_line_delay_ram.sv
// ============================================================================
//  delay_ram
//  DEPTH x DATA_W single-port memory, combinational read, write-on-enable.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module delay_ram #(
  parameter int DATA_W = 48,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Read sees the old contents in the cycle the same address is written.
  assign rdata = r_mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
  end

endmodule

`default_nettype wire

// File: rtl/prog_delay_line.sv
// ============================================================================
//  prog_delay_line
//  Multi-lane run-time programmable delay line with valid tracking, stall and
//  flush. Optional output register: PROG_DELAY_LINE_OUTREG_EN.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module prog_delay_line
  import prog_delay_pkg::*;
#(
  parameter  int WIDTH = 24,
  parameter  int LANES = 2,
  parameter  int DEPTH = 16,
  localparam int DW    = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_load,
  input  logic [DW-1:0]          cfg_delay,
  input  logic                   en,
  input  logic                   in_valid,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   out_valid,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic                   primed,
  output logic                   cfg_err
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]          r_cnt;
  logic [DW-1:0]          r_dly;
  logic [DW-1:0]          r_fill;
  logic [DEPTH-1:0]       r_vld;
  logic                   r_cfg_err;

  logic                   w_last;
  logic                   w_primed;
  logic                   w_legal;
  logic                   w_we;
  logic                   w_out_valid;
  logic [LANES*WIDTH-1:0] w_rdata;

  assign w_last      = (DW'(r_cnt) == (r_dly - DW'(1)));
  assign w_primed    = (r_fill == r_dly);
  assign w_legal     = legal_delay(32'(cfg_delay), DEPTH);
  assign w_we        = en & ~cfg_load & ~rst;
  // Gating by primed hides stale flags left over from a previous delay.
  assign w_out_valid = r_vld[r_cnt] & w_primed;

  delay_ram #(
    .DATA_W (LANES*WIDTH),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .we    (w_we),
    .addr  (r_cnt),
    .wdata (in_data),
    .rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_dly     <= DW'(DEPTH);
      r_fill    <= '0;
      r_vld     <= '0;
      r_cfg_err <= 1'b0;
    end else if (cfg_load) begin
      r_cnt  <= '0;
      r_fill <= '0;
      r_vld  <= '0;
      if (w_legal) begin
        r_dly <= cfg_delay;
      end else begin
        r_cfg_err <= 1'b1;
      end
    end else if (en) begin
      r_cnt        <= w_last ? '0 : r_cnt + AW'(1);
      r_vld[r_cnt] <= in_valid;
      if (!w_primed) begin
        r_fill <= r_fill + DW'(1);
      end
    end
  end

  assign cfg_err = r_cfg_err;

`ifdef PROG_DELAY_LINE_OUTREG_EN
  logic [LANES*WIDTH-1:0] r_out_data;
  logic                   r_out_valid;
  logic                   r_primed;

  always_ff @(posedge clk) begin
    if (rst || cfg_load) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_primed    <= 1'b0;
    end else if (en) begin
      r_out_data  <= w_rdata;
      r_out_valid <= w_out_valid;
      r_primed    <= w_primed;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign primed    = r_primed;
`else
  assign out_data  = w_rdata;
  assign out_valid = w_out_valid;
  assign primed    = w_primed;
`endif

endmodule

`default_nettype wire

// File: tb/tb_prog_delay_line.sv
// ============================================================================
//  tb_prog_delay_line
//  Scoreboard bench: random and directed streams against a sample-index model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_prog_delay_line;
  import prog_delay_pkg::*;

  localparam int WIDTH = 24;
  localparam int LANES = 2;
  localparam int DEPTH = 16;
  localparam int DW    = $clog2(DEPTH + 1);
  localparam int DATW  = LANES * WIDTH;
`ifdef PROG_DELAY_LINE_OUTREG_EN
  localparam int LAT_ADD = 1;
`else
  localparam int LAT_ADD = 0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            cfg_load = 1'b0;
  logic [DW-1:0]   cfg_delay = '0;
  logic            en = 1'b0;
  logic            in_valid = 1'b0;
  logic [DATW-1:0] in_data = '0;
  logic            out_valid;
  logic [DATW-1:0] out_data;
  logic            primed;
  logic            cfg_err;

  prog_delay_line #(.WIDTH(WIDTH), .LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_load  (cfg_load),
    .cfg_delay (cfg_delay),
    .en        (en),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .primed    (primed),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATW-1:0] data;
    int              due;
  } exp_t;

  exp_t q[$];
  int   ecount = 0;      // enabled cycles since last flush
  int   m_dly  = DEPTH;
  logic m_err  = 1'b0;
  logic known  = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [DATW-1:0] mk(input int k);
    lane_t l0;
    l0 = k[WIDTH-1:0];
    return {~l0, l0};
  endfunction

  // Expected output: each accepted valid sample reappears dly(+LAT_ADD) enabled cycles later.
  task automatic drive(input logic r, input logic l, input int d, input logic e,
                       input logic v, input logic [DATW-1:0] dat);
    exp_t x;
    @(posedge clk);
    #1;
    rst = r; cfg_load = l; cfg_delay = DW'(d); en = e; in_valid = v; in_data = dat;
    if (!r && !l && e && v) begin
      x.data = dat;
      x.due  = ecount + m_dly + LAT_ADD;
      q.push_back(x);
    end
  endtask

  task automatic load(input int d);
    drive(1'b0, 1'b1, d, 1'b1, 1'b1, '1);
  endtask

  task automatic stream(input int n, input int base);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 1'b1, 1'b1, mk(base + i));
  endtask

  task automatic idle_en(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 1'b1, 1'b0, mk(32'hdead + i));
  endtask

  // Monitor
  logic            prev_en = 1'b0;
  logic            prev_ov = 1'b0;
  logic [DATW-1:0] prev_od = '0;
  logic            have_prev = 1'b0;

  always @(negedge clk) begin
    logic exp_v;
    if (rst) begin
      q.delete();
      ecount = 0; m_dly = DEPTH; m_err = 1'b0; known = 1'b1; have_prev = 1'b0;
    end else if (known) begin
      chk("primed", 64'(primed), 64'(ecount >= m_dly + LAT_ADD));
      chk("cfg_err", 64'(cfg_err), 64'(m_err));
      if (have_prev && !prev_en) begin
        chk("stall_valid", 64'(out_valid), 64'(prev_ov));
        if (prev_ov) chk("stall_data", 64'(out_data), 64'(prev_od));
      end
      if (cfg_load) begin
        q.delete();
        ecount = 0;
        if (cfg_delay >= 1 && cfg_delay <= DEPTH) m_dly = int'(cfg_delay);
        else m_err = 1'b1;
      end else if (en) begin
        exp_v = (q.size() != 0) && (q[0].due == ecount);
        chk("out_valid", 64'(out_valid), 64'(exp_v));
        if (exp_v) begin
          if (out_valid) chk("out_data", 64'(out_data), 64'(q[0].data));
          void'(q.pop_front());
        end
        ecount++;
      end
      prev_en = en; prev_ov = out_valid; prev_od = out_data; have_prev = !cfg_load;
    end
  end

  initial begin
    drive(1'b1, 1'b0, 0, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, 0, 1'b0, 1'b0, '0);
    // basic latency
    load(5);
    stream(20, 0);
    // stall after the second sample
    load(4);
    stream(2, 10);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 0, 1'b0, 1'b1, mk(99));
    stream(8, 12);
    idle_en(6);
    // reconfigure mid-stream
    load(8);
    stream(12, 100);
    load(3);
    stream(10, 200);
    // boundaries
    load(1);
    stream(8, 300);
    load(16);
    stream(40, 400);
    // illegal configurations keep delay 16
    load(0);
    stream(5, 500);
    load(17);
    stream(20, 520);
    drive(1'b1, 1'b0, 0, 1'b0, 1'b0, '0);
    // reset mid-stream
    load(6);
    stream(3, 600);
    drive(1'b1, 1'b0, 0, 1'b1, 1'b1, mk(700));
    stream(25, 610);
    // random phase
    for (int i = 0; i < 1500; i++) begin
      logic r, l, e, v;
      r = ($urandom_range(0, 399) == 0);
      l = ($urandom_range(0, 99) == 0);
      e = ($urandom_range(0, 3) != 0);
      v = ($urandom_range(0, 9) < 7);
      drive(r, l, $urandom_range(0, 18), e, v, {$urandom(), $urandom()});
    end
    idle_en(DEPTH + 4);
    drive(1'b0, 1'b0, 0, 1'b0, 1'b0, '0);
    @(negedge clk);
    chk("drain_empty", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/prog_delay_line.md
Name: prog_delay_line

Overview:
- Multi-lane, run-time programmable delay line built on a circular memory.
- Successor to the fixed-depth delay buffer. Adds per-entry valid tracking, a stall enable, run-time delay selection and flush.
- Sits between NTT/poly pipeline stages to re-align operand streams whose latency depends on the mode (Kyber/Dilithium).
- Every lane shares one address counter, so one memory read and one write per enabled cycle.

Parameters:
- WIDTH, 24, bits per lane sample.
- LANES, 2, number of parallel lanes delayed together.
- DEPTH, 16, maximum delay in enabled cycles; must be >= 2.
- DW, $clog2(DEPTH+1), width of the delay configuration field (localparam).

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- cfg_load  in  1  load cfg_delay and flush all valid flags.
- cfg_delay  in  DW  requested delay, legal 1..DEPTH.
- en  in  1  advance enable; low = stall, all state held.
- in_valid  in  1  valid tag of the current input sample.
- in_data  in  LANES*WIDTH  input lanes, lane k at [k*WIDTH +: WIDTH].
- out_valid  out  1  valid tag of the delayed sample.
- out_data  out  LANES*WIDTH  delayed lanes.
- primed  out  1  high once delay-many enabled cycles have passed since the last reset or load.
- cfg_err  out  1  sticky; set when cfg_load carries an illegal delay.

Behaviour:
- Reset (sync, active-high) overrides all inputs:
  - cnt=0, dly=DEPTH, all vld bits=0, fill=0, primed=0, cfg_err=0.
  - out_valid=0 in the cycle after reset.
  - Memory data is not reset. out_data is don't-care while out_valid=0.
- Storage:
  - mem[DEPTH] of LANES*WIDTH bits.
  - vld[DEPTH] flag array, flip-flops.
- Address counter cnt (0..DEPTH-1):
  - On en: cnt <= (cnt == dly-1) ? 0 : cnt+1.
  - On !en: cnt held.
- Read-before-write at cnt:
  - out_data = mem[cnt]; out_valid = vld[cnt] (combinational).
  - On en: mem[cnt] <= in_data, vld[cnt] <= in_valid.
- Latency: a sample presented with en=1 appears on out_data exactly dly enabled cycles later. Stalled cycles do not count.
- Stall: en=0 freezes cnt, mem, vld, fill. Outputs stay stable.
- fill counter:
  - Saturates at dly; increments on en.
  - primed = (fill == dly).
  - out_valid is additionally gated by primed, so stale entries from a previous configuration never leak.
- cfg_load:
  - Legal cfg_delay (1..DEPTH): dly <= cfg_delay, cnt <= 0, fill <= 0, all vld <= 0.
  - Illegal cfg_delay (0 or >DEPTH): dly unchanged, flush still performed, cfg_err <= 1.
  - cfg_load has priority over en in the same cycle. The input sample that cycle is dropped, not written.
- dly=1: cnt constantly 0; output equals the previous enabled cycle's input.
- Wrap: cnt wraps at dly-1, not DEPTH-1. Entries above dly-1 are unused.
- Reset mid-operation: all in-flight samples are discarded (valid cleared). Nothing is emitted afterwards until primed.

Optional Feature:
- Macro PROG_DELAY_LINE_OUTREG_EN.
- Defined:
  - out_data and out_valid are registered, captured when en=1. Registers reset to 0 and are cleared on cfg_load.
  - Total latency is dly+1 enabled cycles.
  - primed is delayed identically.
- Undefined: combinational read path as above, latency dly.

Decomposition:
- Package prog_delay_pkg holds:
  - lane_t typedef (logic [WIDTH-1:0]) for default WIDTH;
  - DELAY_MIN=1 constant;
  - function legal_delay(d, depth).
- One natural sub-module, delay_ram: DEPTH x (LANES*WIDTH) single-port memory with combinational read and write-on-enable. It is kept separate so it can be swapped for a memory macro.
- Counter, valid array, fill and cfg logic stay in the top.

Test Plan:
- Basic latency: reset, load delay 5, en=1, in_valid=1, in_data=ramp 0,1,2… → out_valid first at cycle 5 after load, with out_data=0, then 1,2,… every cycle; primed rises with the first valid.
- Stall: delay 4, stream 10..19, en low for 3 cycles after the 2nd sample → out_data sequence 10..19 unbroken and held constant during stall; latency 4 enabled cycles.
- Reconfigure: running at delay 8, cfg_load with delay 3 mid-stream → out_valid=0 for 3 cycles, then the new samples emerge with 3-cycle latency; no old-config data emitted.
- Boundaries: delay 1 → out equals previous input. Delay DEPTH=16 → 16-cycle latency, cnt wraps 15→0.
- Illegal config: cfg_delay=0, then cfg_delay=17 → cfg_err=1 sticky, dly remains prior value, flush observed; reset clears cfg_err.
- Reset mid-stream: delay 6, assert rst for 1 cycle after 3 samples → out_valid stays 0 until 16 enabled cycles later (default dly=DEPTH). Lanes checked independently with distinct per-lane patterns (lane0=k, lane1=~k).
